// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 base datapath
// Drives memory handshakes and one-cycle PC/IR/RF write enables; counts retired instructions.
module core_seq_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             busy,
  output logic             halted,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH
  } cls_t;

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cls_q         <= C_ALU;
      wait_cnt_q    <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      wait_cnt_q    <= wait_cnt_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
      retired_q     <= retired_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    // Counter only survives while a request is stalled, so leaving FETCH/MEM clears it
    wait_cnt_d    = '0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_cnt_q == WC_LIMIT) begin
          state_d       = S_HALT;
          err_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (opcode)
          7'b0110011, 7'b0010011: cls_d = C_ALU;
          7'b0000011:             cls_d = C_LOAD;
          7'b0100011:             cls_d = C_STORE;
          7'b1100011:             cls_d = C_BRANCH;
          7'b1110011:             state_d = S_HALT;
          default: begin
            state_d       = S_HALT;
            err_illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_ALU:   state_d = S_WB;
          C_LOAD:  state_d = S_MEM;
          C_STORE: state_d = S_MEM;
          default: state_d = step_mode ? S_IDLE : S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (cls_q == C_LOAD) ? S_WB : (step_mode ? S_IDLE : S_FETCH);
        end else if (wait_cnt_q == WC_LIMIT) begin
          state_d       = S_HALT;
          err_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_WB:    state_d = step_mode ? S_IDLE : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state_q == S_FETCH);
    ir_we    = (state_q == S_FETCH) && imem_ready;
    dmem_req = (state_q == S_MEM);
    dmem_we  = (state_q == S_MEM) && (cls_q == C_STORE);
    rf_we    = (state_q == S_WB);
    pc_we    = (state_q == S_WB)
             || ((state_q == S_EXEC) && (cls_q == C_BRANCH))
             || ((state_q == S_MEM) && (cls_q == C_STORE) && dmem_ready);
    pc_sel   = (state_q == S_EXEC) && (cls_q == C_BRANCH) && branch_taken;
    busy     = (state_q != S_IDLE) && (state_q != S_HALT);
    halted   = (state_q == S_HALT);
    retired_d = pc_we ? retired_q + CNT_W'(1) : retired_q;
  end

  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign retired     = retired_q;

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV64 base datapath (PC/IR, register file, ALU, immediate generator, data memory).
- Replaces free-running single-cycle stepping with an explicit FETCH/DECODE/EXEC/MEM/WB state machine.
- Handshakes with instruction and data memory, and issues one-cycle write enables to PC, IR and register file.
- Supports run, single-step, halt and memory-timeout error, and keeps a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request is held without ready before error halt (≥2).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level; begins or continues execution from IDLE.
- step_mode  in  1  1 = return to IDLE after each retired instruction.
- opcode  in  7  inst[6:0] from IR, valid from DECODE onward.
- branch_taken  in  1  datapath compare result (Branch AND zero), valid in EXEC.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  fetch request.
- ir_we  out  1  load IR.
- dmem_req  out  1  data access request.
- dmem_we  out  1  store qualifier, valid with dmem_req.
- rf_we  out  1  register file write.
- pc_we  out  1  update PC.
- pc_sel  out  1  0 = PC+4, 1 = PC+(imm<<1) branch target; valid with pc_we.
- busy  out  1  state ≠ IDLE and ≠ HALT.
- halted  out  1  in HALT.
- err_illegal  out  1  sticky, unknown opcode.
- err_timeout  out  1  sticky, memory timeout.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- States:
  - IDLE: start=1 → FETCH.
  - FETCH: imem_req=1; ir_we=imem_ready; on imem_ready → DECODE.
  - DECODE: 1 cycle; classify opcode.
    - 0110011 R-type, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch → EXEC.
    - 1110011 system → HALT; no retire, no errors set.
    - Any other opcode → HALT with err_illegal=1.
  - EXEC: 1 cycle.
    - R/I → WB.
    - Load/store → MEM.
    - Branch retires here: pc_we=1, pc_sel=branch_taken.
  - MEM: dmem_req=1, dmem_we=(store).
    - On dmem_ready, load → WB.
    - On dmem_ready, store retires (pc_we=1, pc_sel=0).
  - WB: rf_we=1, pc_we=1, pc_sel=0, retire.
  - HALT: absorbing; exits only on reset.
- After retire: step_mode=1 → IDLE, otherwise → FETCH. step_mode is sampled in the retiring cycle.
- All outputs are combinational from state and inputs; no other output asserts outside the states listed.
- Latency with zero-wait memory:
  - R/I: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each memory wait cycle adds 1.
- Timeout:
  - wait_cnt clears on entry to FETCH/MEM and increments each cycle ready=0.
  - If wait_cnt reaches MEM_TIMEOUT−1 with ready=0 → HALT, err_timeout=1.
  - Ready in the same cycle as the limit wins (normal progress).
- retired increments by 1 on every cycle with pc_we=1 and wraps modulo 2^CNT_W.
- start is ignored outside IDLE; busy=1 throughout FETCH..WB.
- Reset, including mid-operation:
  - Next state IDLE.
  - retired=0, wait_cnt=0, err_illegal=0, err_timeout=0.
  - All request and enable outputs 0; busy=0; halted=0.
  - Any in-flight memory request is dropped with no write enable.
- ir_we, rf_we and pc_we are each at most one cycle per instruction.

Test Plan:
- Reset, start=1, opcode=0110011, both readies tied 1 → imem_req/ir_we in cycle 1, rf_we+pc_we in cycle 4, retired=1; with start held, next FETCH in cycle 5.
- Load (0000011) with dmem_ready delayed 3 cycles → dmem_req=1, dmem_we=0 for 4 cycles; rf_we follows one cycle later; total 8 cycles; retired increments once.
- Branch (1100011): branch_taken=1 → pc_we=1, pc_sel=1 in cycle 3, no rf_we. Repeat with branch_taken=0 → pc_sel=0.
- step_mode=1, three start pulses with a store (0100011) → exactly 3 retires; IDLE with busy=0 between them; dmem_we=1 with dmem_req.
- opcode=1111111 → HALT after DECODE, err_illegal=1, halted=1, start ignored. opcode=1110011 → HALT with no errors set.
- imem_ready held 0, MEM_TIMEOUT=16 → HALT after 16 FETCH cycles with err_timeout=1; reset mid-wait → all outputs 0 and retired=0 next cycle.
